memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Single-port memory arbiter between the processor's instruction-fetch and data-access paths. It grants the shared RAM port to one requester at a time, forwards address/data/strobes, and returns load data with a per-requester wait signal. It sits between the request unit/datapath and the RAM model. Data requests have priority, bounded by an instruction-starvation limit.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while an instruction request is pending

- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  instruction read request
- iaddr  in  ADDR_W  instruction address
- iload  out  DATA_W  instruction read data
- iwait  out  1  high while an instruction request is not yet complete
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  data write value
- dload  out  DATA_W  data read data
- dwait  out  1  high while a data request is not yet complete
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data, valid when ramready
- ramready  in  1  RAM completes the current access this cycle
- ramerror  in  1  RAM aborts the current access this cycle
- memerr  out  1  sticky error flag

## Operation
- FSM states: IDLE, DGRANT, IGRANT.
- IDLE: all RAM strobes 0.
  - If (dREN|dWEN) and not (iREN and scnt==STARVE_MAX), go to DGRANT.
  - Else if iREN, go to IGRANT.
  - Else stay in IDLE.
- DGRANT:
  - ramaddr=daddr, ramstore=dstore.
  - If dWEN, ramWEN=1 and ramREN=0 (write wins if dREN and dWEN are both set).
  - Else ramREN=1.
- IGRANT: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
- Completion is ramready or ramerror in a grant state. On completion, return to IDLE. The next grant is decided there.
- Requesters hold request, address and store data stable until their wait signal is low.
- iwait = iREN & ~(state==IGRANT & (ramready|ramerror)).
- dwait = (dREN|dWEN) & ~(state==DGRANT & (ramready|ramerror)).
- iload/dload = ramload in the completing cycle of the matching grant, 0 otherwise. On ramerror the load value is 0.
- Starvation counter scnt (width $clog2(STARVE_MAX+1)):
  - Increments on each data completion while iREN=1, saturating at STARVE_MAX.
  - Clears to 0 on instruction completion, or on any cycle in IDLE with iREN=0.
- memerr sets on any ramerror in a grant state and is cleared only by reset.
- Requester withdraws mid-grant (request drops before completion): the access continues to completion, the result is discarded, and the FSM returns to IDLE.

## Timing
- Reset (async, immediate) sets state=IDLE, scnt=0, memerr=0. All RAM outputs go to 0; iload and dload go to 0.
- iwait/dwait follow their requests combinationally, so they are high in reset if a request is driven.
- Reset asserted mid-access drops the RAM strobes in the same cycle with no completion. The RAM must tolerate an aborted access.
- Request seen in IDLE at cycle 0 → grant state and RAM strobes at cycle 1.
- The wait signal goes low in the ramready cycle (cycle ≥1), then the FSM is in IDLE the following cycle.
- Minimum latency: 2 cycles per access; back-to-back accesses cost 1 IDLE bubble each.
- ramready and ramerror together count as error completion: memerr set, load forced to 0.
- ramready/ramerror seen in IDLE is ignored.

## Structure
- Shared package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, DGRANT, IGRANT};
  - word_t (DATA_W) and addr_t (ADDR_W) typedefs, reused by the RAM and request-unit interfaces.
- A memory_arbiter_if interface carries the requester and RAM port bundles.
- No sub-module. The starvation counter is inline.

## Test plan
- Reset with iREN=1: iwait=1, RAM strobes 0, memerr=0. After release, iaddr=0x40 read with ramready on cycle 2 → iload=ramload and iwait=0 on cycle 2, state IDLE on cycle 3.
- iREN and dREN both set in IDLE, daddr=0x100 → DGRANT first, instruction granted after the data completion plus 1 bubble.
- dREN held with iREN held, STARVE_MAX=4, ramready every grant cycle → grant order D,D,D,D,I,D…; scnt=0 after the I completion.
- dWEN=1, dREN=1, dstore=0xDEADBEEF → ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
- ramerror during IGRANT → iload=0, iwait low that cycle, memerr=1 and held until nRST.
- nRST asserted while in DGRANT with ramready pending → ramWEN/ramREN=0 immediately, state IDLE, scnt=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter and the buses around it.
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester and RAM port bundles for the memory arbiter.
interface memory_arbiter_if;
  import mem_arb_pkg::*;

  logic  iREN;
  addr_t iaddr;
  word_t iload;
  logic  iwait;
  logic  dREN;
  logic  dWEN;
  addr_t daddr;
  word_t dstore;
  word_t dload;
  logic  dwait;
  logic  ramREN;
  logic  ramWEN;
  addr_t ramaddr;
  word_t ramstore;
  word_t ramload;
  logic  ramready;
  logic  ramerror;

  modport requester (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  iload, iwait, dload, dwait
  );

  modport ram (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramready, ramerror
  );

endinterface

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: data accesses win, except that a pending fetch is
// granted after STARVE_MAX consecutive data grants.
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready,
  input  logic              ramerror,
  output logic              memerr
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] SCNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] scnt;
  logic             done;
  logic             d_done, i_done;

  assign done   = ramready | ramerror;
  assign d_done = (state_q == DGRANT) & done;
  assign i_done = (state_q == IGRANT) & done;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state_q)
      IDLE: begin
        if ((dREN | dWEN) && !(iREN && scnt == SCNT_MAX)) state_d = DGRANT;
        else if (iREN)                                    state_d = IGRANT;
      end
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        // a simultaneous read+write request is treated as a write
        if (dWEN) ramWEN = 1'b1;
        else      ramREN = 1'b1;
        if (done) state_d = IDLE;
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign iwait = iREN & ~i_done;
  assign dwait = (dREN | dWEN) & ~d_done;
  assign iload = (i_done && !ramerror) ? ramload : '0;
  assign dload = (d_done && !ramerror) ? ramload : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      scnt <= '0;
    end else if (d_done && iREN) begin
      if (scnt != SCNT_MAX) scnt <= scnt + CNT_W'(1);
    end else if (i_done || (state_q == IDLE && !iREN)) begin
      scnt <= '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                  memerr <= 1'b0;
    else if (ramerror && state_q != IDLE)       memerr <= 1'b1;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with hand-computed expectations.
module tb_memory_arbiter;
  import mem_arb_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, ramready, ramerror, memerr;

  int errs   = 0;
  int checks = 0;

  memory_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .ramerror(ramerror),
    .memerr(memerr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic [31:0] exp_addr [6];

  initial begin
    exp_addr[0] = 32'h200; exp_addr[1] = 32'h200; exp_addr[2] = 32'h200;
    exp_addr[3] = 32'h200; exp_addr[4] = 32'h80;  exp_addr[5] = 32'h200;

    nRST = 1'b0; iREN = 1'b1; iaddr = 32'h40; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = '0; ramready = 1'b0; ramerror = 1'b0;
    #3;
    chk("rst_iwait",  iwait,  1'b1);
    chk("rst_ramren", ramREN, 1'b0);
    chk("rst_ramwen", ramWEN, 1'b0);
    chk("rst_memerr", memerr, 1'b0);
    chk("rst_iload",  iload,  32'h0);
    #4 nRST = 1'b1;

    // instruction fetch at 0x40
    step();
    chk("if_ramren", ramREN, 1'b1);
    chk("if_addr",   ramaddr, 32'h40);
    chk("if_iwait_pending", iwait, 1'b1);
    ramready = 1'b1; ramload = 32'h1234_5678;
    #1;
    chk("if_iload", iload, 32'h1234_5678);
    chk("if_iwait", iwait, 1'b0);
    step();
    ramready = 1'b0; iREN = 1'b0;
    #1;
    chk("if_idle", dut.state_q, IDLE);
    chk("if_idle_ren", ramREN, 1'b0);

    // simultaneous requests: data first, fetch after one bubble
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100;
    step();
    chk("pri_dgrant_addr", ramaddr, 32'h100);
    chk("pri_dwait", dwait, 1'b1);
    ramready = 1'b1; ramload = 32'h0000_AAAA;
    #1;
    chk("pri_dload", dload, 32'h0000_AAAA);
    chk("pri_dwait_lo", dwait, 1'b0);
    chk("pri_iwait_hi", iwait, 1'b1);
    chk("pri_iload_0", iload, 32'h0);
    step();
    ramready = 1'b0; dREN = 1'b0;
    #1;
    chk("pri_bubble", ramREN, 1'b0);
    step();
    chk("pri_igrant_addr", ramaddr, 32'h44);
    ramready = 1'b1;
    step();
    iREN = 1'b0; ramready = 1'b0;

    // starvation limit: D,D,D,D,I,D
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h200; ramready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      step();
      chk($sformatf("starve_grant%0d", g), ramaddr, exp_addr[g]);
      step();
      if (g == 3) chk("starve_scnt_sat", dut.scnt, 3'd4);
      if (g == 4) chk("starve_scnt_clr", dut.scnt, 3'd0);
    end
    chk("starve_scnt_after", dut.scnt, 3'd1);
    iREN = 1'b0; dREN = 1'b0; ramready = 1'b0;
    step();

    // write wins over read
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h300; dstore = 32'hDEAD_BEEF;
    step();
    chk("wr_ramwen",  ramWEN, 1'b1);
    chk("wr_ramren",  ramREN, 1'b0);
    chk("wr_store",   ramstore, 32'hDEAD_BEEF);
    chk("wr_addr",    ramaddr, 32'h300);
    ramready = 1'b1;
    #1;
    chk("wr_dwait", dwait, 1'b0);
    step();
    dREN = 1'b0; dWEN = 1'b0; ramready = 1'b0;
    step();

    // error completion during fetch
    iREN = 1'b1; iaddr = 32'h90;
    step();
    ramerror = 1'b1; ramload = 32'h5555_5555;
    #1;
    chk("err_iload", iload, 32'h0);
    chk("err_iwait", iwait, 1'b0);
    step();
    ramerror = 1'b0; iREN = 1'b0;
    #1;
    chk("err_memerr", memerr, 1'b1);
    step(); step();
    chk("err_memerr_hold", memerr, 1'b1);

    // reset in the middle of a data grant
    iREN = 1'b1; iaddr = 32'hA0; dREN = 1'b1; daddr = 32'h400; ramready = 1'b1;
    step();
    step();
    ramready = 1'b0;
    step();
    chk("mid_dgrant", dut.state_q, DGRANT);
    chk("mid_scnt",   dut.scnt, 3'd1);
    chk("mid_ren",    ramREN, 1'b1);
    #1 nRST = 1'b0;
    #1;
    chk("mid_rst_ren",  ramREN, 1'b0);
    chk("mid_rst_wen",  ramWEN, 1'b0);
    chk("mid_rst_st",   dut.state_q, IDLE);
    chk("mid_rst_scnt", dut.scnt, 3'd0);
    chk("mid_rst_err",  memerr, 1'b0);
    chk("mid_rst_dwait", dwait, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
